// File: rtl/demo_dma_lite_slave.sv
// AXI4-Lite register slave modelling a simple-mode DMA (MM2S + S2MM channels).
// LENGTH writes launch the stream movers; done pulses update status and interrupts.
module demo_dma_lite_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_s_axi_lite_awaddr,
    input  logic                  i_s_axi_lite_awvalid,
    output logic                  o_s_axi_lite_awready,
    input  logic [DATA_WIDTH-1:0] i_s_axi_lite_wdata,
    input  logic                  i_s_axi_lite_wvalid,
    output logic                  o_s_axi_lite_wready,
    output logic [1:0]            o_s_axi_lite_bresp,
    output logic                  o_s_axi_lite_bvalid,
    input  logic                  i_s_axi_lite_bready,
    input  logic [ADDR_WIDTH-1:0] i_s_axi_lite_araddr,
    input  logic                  i_s_axi_lite_arvalid,
    output logic                  o_s_axi_lite_arready,
    output logic [DATA_WIDTH-1:0] o_s_axi_lite_rdata,
    output logic [1:0]            o_s_axi_lite_rresp,
    output logic                  o_s_axi_lite_rvalid,
    input  logic                  i_s_axi_lite_rready,
    output logic                  o_mm2s_start,
    output logic                  o_s2mm_start,
    output logic [31:0]           o_mm2s_addr,
    output logic [31:0]           o_s2mm_addr,
    output logic [22:0]           o_mm2s_len,
    output logic [22:0]           o_s2mm_len,
    input  logic                  i_mm2s_done,
    input  logic                  i_s2mm_done,
    output logic                  o_mm2s_introut,
    output logic                  o_s2mm_introut
);

    logic        r_live;
    logic        r_awHeld, r_wHeld;
    logic [7:0]  r_awAddr;
    logic [31:0] r_wData;
    logic        r_bvalid, r_rvalid;
    logic [1:0]  r_bresp, r_rresp;
    logic [31:0] r_rdata;

    // Per-channel state, index 0 = MM2S, index 1 = S2MM
    logic [1:0]  r_rs, r_irqEn, r_idle, r_intErr, r_iocIrq, r_softRst, r_start;
    logic [31:0] r_addr [2];
    logic [22:0] r_len  [2];

    logic        w_awHs, w_wHs, w_arHs, w_commit;
    logic        w_wrCh, w_rdCh, w_wrMapped, w_rdMapped;
    logic [7:0]  w_wrOff, w_rdOff, w_rdAddr;
    logic [31:0] w_rdValue;
    logic [1:0]  w_done;
    logic        w_unusedAddr;

    assign o_s_axi_lite_awready = r_live && !r_awHeld && !r_bvalid;
    assign o_s_axi_lite_wready  = r_live && !r_wHeld && !r_bvalid;
    assign o_s_axi_lite_arready = r_live && !r_rvalid;
    assign o_s_axi_lite_bvalid  = r_bvalid;
    assign o_s_axi_lite_bresp   = r_bresp;
    assign o_s_axi_lite_rvalid  = r_rvalid;
    assign o_s_axi_lite_rresp   = r_rresp;
    assign o_s_axi_lite_rdata   = r_rdata;

    assign w_awHs   = i_s_axi_lite_awvalid && o_s_axi_lite_awready;
    assign w_wHs    = i_s_axi_lite_wvalid && o_s_axi_lite_wready;
    assign w_arHs   = i_s_axi_lite_arvalid && o_s_axi_lite_arready;
    assign w_commit = r_awHeld && r_wHeld;
    assign w_done   = {i_s2mm_done, i_mm2s_done};
    assign w_rdAddr = i_s_axi_lite_araddr[7:0];
    assign w_unusedAddr = &{1'b0, i_s_axi_lite_awaddr[ADDR_WIDTH-1:8], i_s_axi_lite_araddr[ADDR_WIDTH-1:8]};

    assign o_mm2s_start   = r_start[0];
    assign o_s2mm_start   = r_start[1];
    assign o_mm2s_addr    = r_addr[0];
    assign o_s2mm_addr    = r_addr[1];
    assign o_mm2s_len     = r_len[0];
    assign o_s2mm_len     = r_len[1];
    assign o_mm2s_introut = r_iocIrq[0] & r_irqEn[0];
    assign o_s2mm_introut = r_iocIrq[1] & r_irqEn[1];

    // Both channels share one layout, so decode to (channel, offset) and compare offsets
    always_comb begin
        w_wrCh     = (r_awAddr >= 8'h30);
        w_wrOff    = r_awAddr - (w_wrCh ? 8'h30 : 8'h00);
        w_wrMapped = (w_wrOff == 8'h00) || (w_wrOff == 8'h04) || (w_wrOff == 8'h18) || (w_wrOff == 8'h28);
        w_rdCh     = (w_rdAddr >= 8'h30);
        w_rdOff    = w_rdAddr - (w_rdCh ? 8'h30 : 8'h00);
        w_rdMapped = (w_rdOff == 8'h00) || (w_rdOff == 8'h04) || (w_rdOff == 8'h18) || (w_rdOff == 8'h28);
    end

    always_comb begin
        w_rdValue = '0;
        case (w_rdOff)
            8'h00:   w_rdValue = {19'b0, r_irqEn[w_rdCh], 11'b0, r_rs[w_rdCh]};
            8'h04:   w_rdValue = {19'b0, r_iocIrq[w_rdCh], 7'b0, r_intErr[w_rdCh], 2'b0,
                                  r_idle[w_rdCh], !r_rs[w_rdCh]};
            8'h18:   w_rdValue = r_addr[w_rdCh];
            8'h28:   w_rdValue = {9'b0, r_len[w_rdCh]};
            default: w_rdValue = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live   <= 1'b0;
            r_awHeld <= 1'b0;
            r_wHeld  <= 1'b0;
            r_awAddr <= '0;
            r_wData  <= '0;
            r_bvalid <= 1'b0;
            r_bresp  <= 2'b00;
            r_rvalid <= 1'b0;
            r_rresp  <= 2'b00;
            r_rdata  <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_awHs) begin
                r_awHeld <= 1'b1;
                r_awAddr <= i_s_axi_lite_awaddr[7:0];
            end
            if (w_wHs) begin
                r_wHeld <= 1'b1;
                r_wData <= i_s_axi_lite_wdata;
            end
            if (w_commit) begin
                r_awHeld <= 1'b0;
                r_wHeld  <= 1'b0;
                r_bvalid <= 1'b1;
                r_bresp  <= w_wrMapped ? 2'b00 : 2'b10;
            end else if (r_bvalid && i_s_axi_lite_bready) begin
                r_bvalid <= 1'b0;
            end
            if (w_arHs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rdValue;
                r_rresp  <= w_rdMapped ? 2'b00 : 2'b10;
            end else if (r_rvalid && i_s_axi_lite_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // Later statements take priority: done beats W1C, and a pending soft reset beats everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rs      <= '0;
            r_irqEn   <= '0;
            r_idle    <= '1;
            r_intErr  <= '0;
            r_iocIrq  <= '0;
            r_softRst <= '0;
            r_start   <= '0;
            for (int c = 0; c < 2; c++) begin
                r_addr[c] <= '0;
                r_len[c]  <= '0;
            end
        end else begin
            r_start   <= '0;
            r_softRst <= '0;
            for (int c = 0; c < 2; c++) begin
                if (w_commit && (w_wrCh == c[0])) begin
                    case (w_wrOff)
                        8'h00: begin
                            r_rs[c]      <= r_wData[0];
                            r_irqEn[c]   <= r_wData[12];
                            r_softRst[c] <= r_wData[2];
                        end
                        8'h04: begin
                            if (r_wData[4])  r_intErr[c] <= 1'b0;
                            if (r_wData[12]) r_iocIrq[c] <= 1'b0;
                        end
                        8'h18: r_addr[c] <= r_wData;
                        8'h28: begin
                            r_len[c] <= r_wData[22:0];
                            if (r_rs[c] && r_idle[c] && (r_wData[22:0] != 23'd0)) begin
                                r_idle[c]  <= 1'b0;
                                r_start[c] <= 1'b1;
                            end else begin
                                r_intErr[c] <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                if (w_done[c] && !r_idle[c]) begin
                    r_idle[c]   <= 1'b1;
                    r_iocIrq[c] <= 1'b1;
                end
                if (r_softRst[c]) begin
                    r_rs[c]     <= 1'b0;
                    r_irqEn[c]  <= 1'b0;
                    r_idle[c]   <= 1'b1;
                    r_intErr[c] <= 1'b0;
                    r_iocIrq[c] <= 1'b0;
                    r_start[c]  <= 1'b0;
                    r_addr[c]   <= '0;
                    r_len[c]    <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_demo_dma_lite_slave.sv
// Directed self-checking bench for demo_dma_lite_slave: register map, start pulses,
// completion/interrupts, error paths and write-channel back-pressure.
module tb_demo_dma_lite_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        mm2sStart, s2mmStart, mm2sIrq, s2mmIrq;
    logic        mm2sDone = 1'b0, s2mmDone = 1'b0;
    logic [31:0] mm2sAddr, s2mmAddr;
    logic [22:0] mm2sLen, s2mmLen;

    int          total = 0;
    int          bad = 0;
    int          mm2sStarts = 0;
    int          s2mmStarts = 0;
    logic [31:0] mm2sAddrAtStart = '0;
    logic [22:0] mm2sLenAtStart = '0;

    demo_dma_lite_slave dut (
        .clk(clk), .rst(rst),
        .i_s_axi_lite_awaddr(awaddr), .i_s_axi_lite_awvalid(awvalid), .o_s_axi_lite_awready(awready),
        .i_s_axi_lite_wdata(wdata), .i_s_axi_lite_wvalid(wvalid), .o_s_axi_lite_wready(wready),
        .o_s_axi_lite_bresp(bresp), .o_s_axi_lite_bvalid(bvalid), .i_s_axi_lite_bready(bready),
        .i_s_axi_lite_araddr(araddr), .i_s_axi_lite_arvalid(arvalid), .o_s_axi_lite_arready(arready),
        .o_s_axi_lite_rdata(rdata), .o_s_axi_lite_rresp(rresp), .o_s_axi_lite_rvalid(rvalid),
        .i_s_axi_lite_rready(rready),
        .o_mm2s_start(mm2sStart), .o_s2mm_start(s2mmStart),
        .o_mm2s_addr(mm2sAddr), .o_s2mm_addr(s2mmAddr),
        .o_mm2s_len(mm2sLen), .o_s2mm_len(s2mmLen),
        .i_mm2s_done(mm2sDone), .i_s2mm_done(s2mmDone),
        .o_mm2s_introut(mm2sIrq), .o_s2mm_introut(s2mmIrq)
    );

    always #5 clk = ~clk;

    // Start pulses are tallied on the falling edge so their width is counted in cycles
    always @(negedge clk) begin
        if (mm2sStart) begin
            mm2sStarts++;
            mm2sAddrAtStart = mm2sAddr;
            mm2sLenAtStart  = mm2sLen;
        end
        if (s2mmStart) s2mmStarts++;
    end

    task automatic axiWrite(input logic [7:0] addr, input logic [31:0] data,
                            output logic [1:0] resp, output logic startAtB);
        bit awPend, wPend, awTake, wTake;
        int n;
        @(negedge clk);
        awaddr = {24'h0, addr}; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
        awPend = 1'b1; wPend = 1'b1; n = 0;
        while ((awPend || wPend) && n < 50) begin
            awTake = awvalid && awready;
            wTake  = wvalid && wready;
            @(posedge clk); #1;
            if (awTake) begin awvalid = 1'b0; awPend = 1'b0; end
            if (wTake)  begin wvalid = 1'b0; wPend = 1'b0; end
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        resp = 2'b11; startAtB = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        if (!bvalid) begin
            total++; bad++;
            $display("[TB] FAIL write_timeout addr=%h got bvalid=0 exp bvalid=1", addr);
        end else begin
            resp = bresp;
            startAtB = mm2sStart | s2mmStart;
            bready = 1'b1;
            @(posedge clk); #1;
            bready = 1'b0;
        end
    endtask

    task automatic axiRead(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit take;
        int n;
        @(negedge clk);
        araddr = {24'h0, addr}; arvalid = 1'b1; n = 0; take = 1'b0;
        while (!take && n < 50) begin
            take = arready;
            @(posedge clk); #1;
            n++;
        end
        arvalid = 1'b0;
        data = 32'hDEAD_BEEF; resp = 2'b11;
        n = 0;
        @(negedge clk);
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        if (!rvalid) begin
            total++; bad++;
            $display("[TB] FAIL read_timeout addr=%h got rvalid=0 exp rvalid=1", addr);
        end else begin
            data = rdata; resp = rresp;
            rready = 1'b1;
            @(posedge clk); #1;
            rready = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({awready, wready, arready, bvalid, rvalid, bresp, rresp} !== 9'b0 || rdata !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_bus got rdy=%b%b%b bv=%b rv=%b rdata=%h exp all 0",
                     awready, wready, arready, bvalid, rvalid, rdata);
        end
        total++;
        if ({mm2sStart, s2mmStart, mm2sIrq, s2mmIrq} !== 4'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got %b exp 0000", {mm2sStart, s2mmStart, mm2sIrq, s2mmIrq});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({awready, wready, arready} !== 3'b111) begin
            bad++;
            $display("[TB] FAIL ready_after_reset got %b exp 111", {awready, wready, arready});
        end
        axiRead(8'h04, d, r);
        total++;
        if (d !== 32'h3 || r !== 2'b00) begin
            bad++;
            $display("[TB] FAIL mm2s_sr_reset got %h/%b exp 00000003/00", d, r);
        end
        axiRead(8'h34, d, r);
        total++;
        if (d !== 32'h3 || r !== 2'b00) begin
            bad++;
            $display("[TB] FAIL s2mm_sr_reset got %h/%b exp 00000003/00", d, r);
        end
    endtask

    task automatic test_mm2s_start();
        logic [31:0] d;
        logic [1:0]  r;
        logic        s;
        axiWrite(8'h00, 32'h1001, r, s);
        axiWrite(8'h18, 32'h1000_0000, r, s);
        axiWrite(8'h28, 32'h400, r, s);
        total++;
        if (r !== 2'b00 || s !== 1'b1) begin
            bad++;
            $display("[TB] FAIL len_write_resp got bresp=%b start_at_b=%b exp 00/1", r, s);
        end
        repeat (3) @(negedge clk);
        total++;
        if (mm2sStarts !== 1 || s2mmStarts !== 0) begin
            bad++;
            $display("[TB] FAIL start_pulse_count got mm2s=%0d s2mm=%0d exp 1/0", mm2sStarts, s2mmStarts);
        end
        total++;
        if (mm2sAddrAtStart !== 32'h1000_0000 || mm2sLenAtStart !== 23'h400) begin
            bad++;
            $display("[TB] FAIL start_addr_len got %h/%h exp 10000000/000400", mm2sAddrAtStart, mm2sLenAtStart);
        end
        axiRead(8'h04, d, r);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("[TB] FAIL mm2s_sr_busy got %h exp 00000000", d);
        end
    endtask

    task automatic test_done_irq();
        logic [31:0] d;
        logic [1:0]  r;
        logic        s;
        @(negedge clk); mm2sDone = 1'b1;
        @(negedge clk); mm2sDone = 1'b0;
        total++;
        if (mm2sIrq !== 1'b1 || s2mmIrq !== 1'b0) begin
            bad++;
            $display("[TB] FAIL introut_after_done got mm2s=%b s2mm=%b exp 1/0", mm2sIrq, s2mmIrq);
        end
        axiRead(8'h04, d, r);
        total++;
        if (d !== 32'h1002) begin
            bad++;
            $display("[TB] FAIL mm2s_sr_done got %h exp 00001002", d);
        end
        axiWrite(8'h04, 32'h1000, r, s);
        @(negedge clk);
        total++;
        if (mm2sIrq !== 1'b0) begin
            bad++;
            $display("[TB] FAIL introut_after_w1c got %b exp 0", mm2sIrq);
        end
        axiRead(8'h04, d, r);
        total++;
        if (d !== 32'h2) begin
            bad++;
            $display("[TB] FAIL mm2s_sr_w1c got %h exp 00000002", d);
        end
        // A done while already idle must not raise the interrupt again
        @(negedge clk); mm2sDone = 1'b1;
        @(negedge clk); mm2sDone = 1'b0;
        axiRead(8'h04, d, r);
        total++;
        if (d !== 32'h2 || mm2sIrq !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_done_ignored got %h irq=%b exp 00000002/0", d, mm2sIrq);
        end
    endtask

    task automatic test_len_error();
        logic [31:0] d;
        logic [1:0]  r;
        logic        s;
        axiWrite(8'h58, 32'h80, r, s);
        repeat (3) @(negedge clk);
        total++;
        if (s2mmStarts !== 0 || r !== 2'b00) begin
            bad++;
            $display("[TB] FAIL halted_len_write got starts=%0d bresp=%b exp 0/00", s2mmStarts, r);
        end
        axiRead(8'h34, d, r);
        total++;
        if (d !== 32'h13) begin
            bad++;
            $display("[TB] FAIL s2mm_sr_err got %h exp 00000013", d);
        end
        axiRead(8'h58, d, r);
        total++;
        if (d !== 32'h80 || s2mmLen !== 23'h80) begin
            bad++;
            $display("[TB] FAIL s2mm_len got %h port=%h exp 00000080", d, s2mmLen);
        end
        axiWrite(8'h34, 32'h10, r, s);
        axiRead(8'h34, d, r);
        total++;
        if (d !== 32'h3) begin
            bad++;
            $display("[TB] FAIL s2mm_sr_clear got %h exp 00000003", d);
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] d;
        logic [1:0]  r;
        @(negedge clk);
        wdata = 32'hCAFE_0000; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        total++;
        if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL w_held got wr=%b awr=%b bv=%b exp 0/1/0", wready, awready, bvalid);
        end
        @(negedge clk);
        @(negedge clk);
        awaddr = 32'h48; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        total++;
        if (bvalid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL commit_latency got bvalid=%b exp 0", bvalid);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            awvalid = 1'b1; awaddr = 32'h18; wvalid = 1'b1; wdata = 32'h5555_5555;
            @(negedge clk);
            total++;
            if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL bp_cycle%0d got bv=%b bresp=%b awr=%b wr=%b exp 1/00/0/0",
                         i, bvalid, bresp, awready, wready);
            end
            @(posedge clk); #1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        total++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b_release got bv=%b awr=%b exp 0/1", bvalid, awready);
        end
        repeat (3) @(negedge clk);
        total++;
        if (bvalid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_commit got bvalid=%b exp 0", bvalid);
        end
        axiRead(8'h48, d, r);
        total++;
        if (d !== 32'hCAFE_0000 || s2mmAddr !== 32'hCAFE_0000) begin
            bad++;
            $display("[TB] FAIL s2mm_da got %h port=%h exp cafe0000", d, s2mmAddr);
        end
        axiRead(8'h18, d, r);
        total++;
        if (d !== 32'h1000_0000) begin
            bad++;
            $display("[TB] FAIL mm2s_sa_untouched got %h exp 10000000", d);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        logic [1:0]  r;
        logic        s;
        axiRead(8'h7C, d, r);
        total++;
        if (d !== 32'h0 || r !== 2'b10) begin
            bad++;
            $display("[TB] FAIL unmapped_read got %h/%b exp 00000000/10", d, r);
        end
        axiWrite(8'h20, 32'hFFFF_FFFF, r, s);
        total++;
        if (r !== 2'b10 || s !== 1'b0) begin
            bad++;
            $display("[TB] FAIL unmapped_write got bresp=%b start=%b exp 10/0", r, s);
        end
        axiRead(8'h00, d, r);
        total++;
        if (d !== 32'h1001 || r !== 2'b00) begin
            bad++;
            $display("[TB] FAIL cr_untouched got %h/%b exp 00001001/00", d, r);
        end
        axiRead(8'h28, d, r);
        total++;
        if (d !== 32'h400 || mm2sStarts !== 1) begin
            bad++;
            $display("[TB] FAIL len_untouched got %h starts=%0d exp 00000400/1", d, mm2sStarts);
        end
    endtask

    task automatic test_soft_reset();
        logic [31:0] d;
        logic [1:0]  r;
        logic        s;
        axiWrite(8'h00, 32'h0000_1005, r, s);
        axiRead(8'h00, d, r);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("[TB] FAIL soft_reset_cr got %h exp 00000000", d);
        end
        axiRead(8'h18, d, r);
        total++;
        if (d !== 32'h0 || mm2sLen !== 23'h0) begin
            bad++;
            $display("[TB] FAIL soft_reset_sa got %h len=%h exp 0/0", d, mm2sLen);
        end
        axiRead(8'h48, d, r);
        total++;
        if (d !== 32'hCAFE_0000) begin
            bad++;
            $display("[TB] FAIL soft_reset_other_ch got %h exp cafe0000", d);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout exp completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_mm2s_start();
        test_done_irq();
        test_len_error();
        test_back_pressure();
        test_unmapped();
        test_soft_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demo_dma_lite_slave.md
# demo_dma_lite_slave

AXI4-Lite responder that terminates the accelerator's DMA-control master port. Implements a subset of a simple-mode AXI DMA register map (MM2S and S2MM channels), converts LENGTH writes into one-cycle transfer-start pulses for the stream movers, and tracks completion, status and interrupts. Sits between the accelerator top's `m_axi_lite_*` master and the DDR stream movers, and serves as the bench model of the DMA engine.

## Interface
- `ADDR_WIDTH`, default `CONF_AXI_ADDR_WIDTH` (`diff_demo_pkg`): AXI-Lite address width. Only bits [7:0] are decoded.
- `DATA_WIDTH`, default `CONF_AXI_DATA_WIDTH`, fixed at 32: register width.
- `clk`  in  1  single clock for the block.
- `rst`  in  1  asynchronous, active-high reset.
- `s_axi_lite_awaddr`/`awvalid`/`awready`  in/in/out  ADDR_WIDTH/1/1  write-address channel.
- `s_axi_lite_wdata`/`wvalid`/`wready`  in/in/out  DATA_WIDTH/1/1  write-data channel. No strobes; full-word writes.
- `s_axi_lite_bresp`/`bvalid`/`bready`  out/out/in  2/1/1  write-response channel.
- `s_axi_lite_araddr`/`arvalid`/`arready`  in/in/out  ADDR_WIDTH/1/1  read-address channel.
- `s_axi_lite_rdata`/`rresp`/`rvalid`/`rready`  out/out/out/in  DATA_WIDTH/2/1/1  read-data channel.
- `mm2s_start`, `s2mm_start`  out  1  one-cycle launch pulse per channel.
- `mm2s_addr`, `s2mm_addr`  out  32  SA / DA register contents.
- `mm2s_len`, `s2mm_len`  out  23  LENGTH register contents, in bytes.
- `mm2s_done`, `s2mm_done`  in  1  one-cycle completion pulse from the mover.
- `mm2s_introut`, `s2mm_introut`  out  1  level interrupt per channel.

## Operation
- Register map, per channel at base B (MM2S B=0x00, S2MM B=0x30):
  - B+0x00 DMACR: bit0 RS, bit2 Reset (self-clearing), bit12 IOC_IrqEn.
  - B+0x04 DMASR: bit0 Halted (= !RS), bit1 Idle, bit4 DMAIntErr, bit12 IOC_Irq. Bits 4 and 12 are write-1-to-clear. Other bits are read-only.
  - Address register: MM2S SA at 0x18, S2MM DA at 0x48.
  - LENGTH: MM2S at 0x28, S2MM at 0x58, bits [22:0].
- Any other address is unmapped:
  - Read returns 0 with `rresp`=2'b10 (SLVERR).
  - Write has no effect and returns `bresp`=2'b10.
  - Mapped accesses return 2'b00.
- Write handling:
  - AW and W are captured independently into holding registers, at most one of each outstanding.
  - `awready` = !aw_held && !bvalid. `wready` = !w_held && !bvalid.
  - When both are held, commit the write, clear both holds and assert `bvalid`.
  - `bvalid` drops on `bready`.
- Read handling: `arready` = !rvalid. On an AR handshake, register `rdata`/`rresp` and assert `rvalid`. `rvalid` holds until `rready`.
- LENGTH write:
  - If RS=1, Idle=1 and the value is nonzero: update LENGTH, clear Idle, pulse `*_start` on the cycle after commit.
  - If RS=0, Idle=0 or the value is zero: update LENGTH, no start, set DMAIntErr.
- `*_done` while Idle=0: set Idle, and set IOC_Irq. A `*_done` while Idle=1 is ignored.
- `*_introut` = IOC_Irq & IOC_IrqEn.
- DMACR Reset=1 write: the next cycle restores that channel's registers to reset values. Bit 2 always reads 0.
- Simultaneous events:
  - Read and write to the same register on the same edge: the read returns the pre-write value.
  - `*_done` on the same edge as a W1C of IOC_Irq: the set wins.

## Timing
- Reset values:
  - All `*ready`, `bvalid`, `rvalid`, `bresp`, `rresp` and `rdata` are 0 during reset.
  - `awready`/`wready`/`arready` become 1 on the first edge after `rst` deasserts.
  - Registers: RS=0, Halted=1, Idle=1, IOC_IrqEn=0, all other bits 0.
  - `*_start` and `*_introut` are 0.
- Write latency:
  - AW and W handshake at edge N: the register updates and `bvalid`=1 at edge N+1.
  - A LENGTH start pulse is high during N+1..N+2.
  - AW and W handshakes may occur on different edges; commit happens one edge after the later one.
- Read latency: AR handshake at edge N gives `rvalid`=1 with data after edge N.
- Back-pressure: with `bready`=0 (or `rready`=0), no new AW/W (or AR) is accepted. Outputs stay stable until the handshake.
- `rst` mid-transaction: all holds and valids clear immediately. No partial write commits.

## Test plan
- Reset, then read 0x04 -> `rdata`=0x0000_0003, `rresp`=0. Read 0x34 -> 0x0000_0003.
- Write 0x00=0x1001, 0x18=0x1000_0000, then 0x28=0x400 -> exactly one `mm2s_start` pulse with `mm2s_addr`=0x1000_0000, `mm2s_len`=0x400. A read of 0x04 then returns 0x0000_0000.
- Pulse `mm2s_done` -> 0x04 reads 0x0000_1002 and `mm2s_introut`=1. Write 0x04=0x1000 -> `mm2s_introut`=0 and 0x04 reads 0x0000_0002.
- With RS=0, write 0x58=0x80 -> no `s2mm_start`, 0x34 reads 0x0000_0013. Write 0x34=0x10 -> reads 0x0000_0003.
- Present W two cycles before AW to 0x48, with `bready` low for 3 cycles -> single commit, `bvalid` held stable, `awready` low until B completes, `bresp`=0.
- Read 0x7C and write 0x20 -> `rresp`=2'b10, `rdata`=0, `bresp`=2'b10, no register changed.
